// File: rtl/mic1_ctrl_pkg.sv
// Shared types and constants for the MIC-1 run/stop/step sequencer.
package mic1_ctrl_pkg;

  typedef enum logic [2:0] {RST_HOLD, IDLE, RUN, STOP, STEP, FAULT} run_state_t;

  localparam int BTN_RUN  = 0;
  localparam int BTN_STEP = 2;
  localparam int BTN_STOP = 3;
  localparam int BTN_RST  = 4;

  // Status LEDs for a given state; bit 2 mirrors an outstanding request.
  function automatic logic [5:0] led_of(input run_state_t s, input logic req);
    logic [5:0] l;
    case (s)
      RUN:         l = 6'b000001;
      IDLE, STOP:  l = 6'b000010;
      STEP:        l = 6'b001000;
      RST_HOLD:    l = 6'b010000;
      default:     l = 6'b100000;
    endcase
    return l | {3'b000, req, 2'b00};
  endfunction

endpackage

// File: rtl/btn_edge_detect.sv
// Rising-edge detector: one-cycle press pulse per bit against a registered prior level.
module btn_edge_detect #(
  parameter int W = 5
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic [W-1:0] i_lvl,
  output logic [W-1:0] o_press
);

  logic [W-1:0] r_prev;

  always_ff @(posedge i_clk) begin
    if (i_reset) r_prev <= '0;
    else         r_prev <= i_lvl;
  end

  assign o_press = i_lvl & ~r_prev;

endmodule

// File: rtl/mic1_run_ctrl.sv
// Front-panel run/stop/step sequencer pacing the MIC-1 datapath via req/ack,
// with timed datapath reset, ack timeout and status LEDs.
module mic1_run_ctrl
  import mic1_ctrl_pkg::*;
#(
  parameter int RST_CYCLES  = 4,
  parameter int RATE_DIV    = 0,
  parameter int ACK_TIMEOUT = 1023,
  parameter int CNT_W       = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [4:0]       i_btn,
  input  logic             i_cpu_halt,
  input  logic             i_cpu_ack,
  output logic             o_cpu_req,
  output logic             o_cpu_rst,
  output logic [CNT_W-1:0] o_step_cnt,
  output logic [5:0]       o_led
);

  localparam int HOLD_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int GAP_W  = (RATE_DIV > 1) ? $clog2(RATE_DIV) : 1;
  localparam int WAIT_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(RST_CYCLES - 1);
  localparam logic [GAP_W-1:0]  GAP_INIT  = GAP_W'((RATE_DIV > 0) ? RATE_DIV - 1 : 0);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(ACK_TIMEOUT - 1);

  run_state_t         r_state, w_nxt_state;
  logic [HOLD_W-1:0]  r_hold_cnt, w_nxt_hold;
  logic [GAP_W-1:0]   r_gap_cnt, w_nxt_gap;
  logic [WAIT_W-1:0]  r_wait_cnt, w_nxt_wait;
  logic [CNT_W-1:0]   r_step_cnt, w_nxt_cnt;
  logic               r_req, w_nxt_req;
  logic               r_stop_pend, w_nxt_pend;
  logic               r_rst;
  logic [5:0]         r_led;

  logic [4:0] w_press;
  logic       w_unused_press;
  logic       w_ev_rst, w_ev_stop, w_ev_run, w_ev_step;
  logic       w_ack, w_timeout, w_stop_now;

  btn_edge_detect #(.W(5)) u_edge (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_lvl   (i_btn),
    .o_press (w_press)
  );

  assign w_unused_press = w_press[1];

  // Only the highest-priority press acts in a given cycle.
  assign w_ev_rst  = w_press[BTN_RST];
  assign w_ev_stop = w_press[BTN_STOP] & ~w_ev_rst;
  assign w_ev_run  = w_press[BTN_RUN]  & ~w_press[BTN_STOP] & ~w_ev_rst;
  assign w_ev_step = w_press[BTN_STEP] & ~w_press[BTN_RUN] & ~w_press[BTN_STOP] & ~w_ev_rst;

  assign w_ack      = r_req & i_cpu_ack;
  assign w_timeout  = r_req & ~i_cpu_ack & (r_wait_cnt == WAIT_LAST);
  assign w_stop_now = r_stop_pend | w_ev_stop | i_cpu_halt;

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_req   = r_req;
    w_nxt_pend  = r_stop_pend;
    w_nxt_hold  = r_hold_cnt;
    w_nxt_gap   = r_gap_cnt;
    w_nxt_wait  = r_wait_cnt;
    w_nxt_cnt   = r_step_cnt + CNT_W'(w_ack);
    case (r_state)
      RST_HOLD: begin
        if (r_hold_cnt == '0) w_nxt_state = IDLE;
        else                  w_nxt_hold  = r_hold_cnt - HOLD_W'(1);
      end
      IDLE, STOP: begin
        if (w_ev_stop && r_state == IDLE) begin
          w_nxt_state = STOP;
        end else if (w_ev_run || w_ev_step) begin
          w_nxt_state = w_ev_run ? RUN : STEP;
          w_nxt_req   = 1'b1;
          w_nxt_wait  = '0;
          w_nxt_pend  = 1'b0;
        end
      end
      RUN: begin
        if (w_timeout) begin
          w_nxt_state = FAULT;
          w_nxt_req   = 1'b0;
        end else if (!r_req) begin
          // Pacing gap: nothing outstanding, so a stop can take effect at once.
          if (w_stop_now) begin
            w_nxt_state = STOP;
            w_nxt_pend  = 1'b0;
          end else if (r_gap_cnt == '0) begin
            w_nxt_req  = 1'b1;
            w_nxt_wait = '0;
          end else begin
            w_nxt_gap = r_gap_cnt - GAP_W'(1);
          end
        end else if (i_cpu_ack) begin
          if (w_stop_now) begin
            w_nxt_state = STOP;
            w_nxt_req   = 1'b0;
            w_nxt_pend  = 1'b0;
          end else if (RATE_DIV == 0) begin
            w_nxt_wait = '0;
          end else begin
            w_nxt_req = 1'b0;
            w_nxt_gap = GAP_INIT;
          end
        end else begin
          w_nxt_pend = w_stop_now;
          w_nxt_wait = r_wait_cnt + WAIT_W'(1);
        end
      end
      STEP: begin
        if (w_timeout) begin
          w_nxt_state = FAULT;
          w_nxt_req   = 1'b0;
        end else if (w_ack) begin
          w_nxt_state = STOP;
          w_nxt_req   = 1'b0;
          w_nxt_pend  = 1'b0;
        end else begin
          w_nxt_pend = r_stop_pend | w_ev_stop;
          w_nxt_wait = r_wait_cnt + WAIT_W'(1);
        end
      end
      default: ;
    endcase
    // Sync reset abandons any transaction, including an ack arriving this cycle.
    if (w_ev_rst) begin
      w_nxt_state = RST_HOLD;
      w_nxt_hold  = HOLD_INIT;
      w_nxt_req   = 1'b0;
      w_nxt_pend  = 1'b0;
      w_nxt_cnt   = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= RST_HOLD;
      r_hold_cnt  <= HOLD_INIT;
      r_gap_cnt   <= '0;
      r_wait_cnt  <= '0;
      r_step_cnt  <= '0;
      r_req       <= 1'b0;
      r_stop_pend <= 1'b0;
      r_rst       <= 1'b1;
      r_led       <= 6'b010000;
    end else begin
      r_state     <= w_nxt_state;
      r_hold_cnt  <= w_nxt_hold;
      r_gap_cnt   <= w_nxt_gap;
      r_wait_cnt  <= w_nxt_wait;
      r_step_cnt  <= w_nxt_cnt;
      r_req       <= w_nxt_req;
      r_stop_pend <= w_nxt_pend;
      r_rst       <= (w_nxt_state == RST_HOLD);
      r_led       <= led_of(w_nxt_state, w_nxt_req);
    end
  end

  assign o_cpu_req  = r_req;
  assign o_cpu_rst  = r_rst;
  assign o_step_cnt = r_step_cnt;
  assign o_led      = r_led;

endmodule

// File: tb/tb_mic1_run_ctrl.sv
// Directed plus randomized bench for mic1_run_ctrl against a behavioural model.
module tb_mic1_run_ctrl;

  localparam int RSTC = 4;
  localparam int RDIV = 2;
  localparam int TO   = 8;
  localparam int CW   = 2;
  localparam int MH = 0, MI = 1, MR = 2, MS = 3, MT = 4, MF = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          halt = 1'b0;
  logic          ack = 1'b0;
  logic [4:0]    btn = '0;
  logic          req, crst;
  logic [CW-1:0] cnt;
  logic [5:0]    led;

  always #5 clk = ~clk;

  mic1_run_ctrl #(
    .RST_CYCLES(RSTC), .RATE_DIV(RDIV), .ACK_TIMEOUT(TO), .CNT_W(CW)
  ) dut (
    .i_clk(clk), .i_reset(reset), .i_btn(btn), .i_cpu_halt(halt), .i_cpu_ack(ack),
    .o_cpu_req(req), .o_cpu_rst(crst), .o_step_cnt(cnt), .o_led(led)
  );

  int checks = 0;
  int errors = 0;
  int req_hi, rst_hi;

  // Reference model: mode, cycles of datapath reset left, request bookkeeping.
  int m_mode, m_left, m_cnt, m_wait, m_gap, m_age, lat;
  bit m_req, m_pend;
  logic [4:0] m_prev;
  logic [4:0] b;
  bit h, force_ack, spur_en;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [5:0] exp_led();
    logic [5:0] l;
    case (m_mode)
      MR:      l = 6'd1;
      MI, MS:  l = 6'd2;
      MT:      l = 6'd8;
      MH:      l = 6'd16;
      default: l = 6'd32;
    endcase
    return m_req ? (l | 6'd4) : l;
  endfunction

  task automatic model_reset();
    m_mode = MH; m_left = RSTC; m_req = 0; m_cnt = 0; m_pend = 0;
    m_wait = 0; m_gap = 0; m_prev = '0; m_age = 0;
  endtask

  task automatic model_clock(input logic [4:0] bt, input bit hl, input bit ak);
    logic [4:0] ev;
    bit rs, sp, rn, st, acked, stopreq, old_req;
    ev = bt & ~m_prev;
    m_prev = bt;
    rs = ev[4];
    sp = ev[3] && !rs;
    rn = ev[0] && !ev[3] && !rs;
    st = ev[2] && !ev[0] && !ev[3] && !rs;
    acked = m_req && ak;
    old_req = m_req;
    if (rs) begin
      m_mode = MH; m_left = RSTC; m_req = 0; m_cnt = 0; m_pend = 0;
    end else begin
      if (acked) m_cnt = (m_cnt + 1) % (1 << CW);
      stopreq = m_pend || sp || hl;
      case (m_mode)
        MH: begin
          m_left--;
          if (m_left == 0) m_mode = MI;
        end
        MI, MS: begin
          if (sp && m_mode == MI) m_mode = MS;
          else if (rn || st) begin
            m_mode = rn ? MR : MT; m_req = 1; m_wait = 0; m_pend = 0;
          end
        end
        MR: begin
          if (m_req && !ak) begin
            m_wait++;
            if (m_wait == TO) begin m_mode = MF; m_req = 0; end
            else m_pend = stopreq;
          end else if (m_req) begin
            if (stopreq) begin m_mode = MS; m_req = 0; m_pend = 0; end
            else begin m_req = 0; m_gap = RDIV; end
          end else if (stopreq) begin
            m_mode = MS; m_pend = 0;
          end else begin
            m_gap--;
            if (m_gap == 0) begin m_req = 1; m_wait = 0; end
          end
        end
        MT: begin
          if (m_req && !ak) begin
            m_wait++;
            if (m_wait == TO) begin m_mode = MF; m_req = 0; end
            else m_pend = m_pend || sp;
          end else if (m_req) begin
            m_mode = MS; m_req = 0; m_pend = 0;
          end
        end
        default: ;
      endcase
    end
    if (m_req) m_age = (old_req && !acked) ? m_age + 1 : 1;
    else       m_age = 0;
  endtask

  // One clock: drive inputs, advance model, sample DUT after the edge.
  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      bit a;
      a = force_ack || (m_req && lat != 0 && m_age == lat) ||
          (!m_req && spur_en && $urandom_range(0, 3) == 0);
      btn = b; halt = h; ack = a;
      if (reset) model_reset();
      else       model_clock(b, h, a);
      @(posedge clk); #1;
      chk("cpu_req", req, m_req);
      chk("cpu_rst", crst, m_mode == MH);
      chk("step_cnt", cnt, m_cnt);
      chk("led", led, exp_led());
      if (req)  req_hi++;
      if (crst) rst_hi++;
    end
  endtask

  initial begin
    b = '0; h = 0; force_ack = 0; spur_en = 0; lat = 1;
    req_hi = 0; rst_hi = 0;
    model_reset();

    reset = 1; cyc(2);
    chk("reset_led", led, 6'b010000);
    rst_hi = int'(crst);
    reset = 0; cyc(6);
    chk("rst_len", rst_hi, RSTC);
    chk("idle_led", led, 6'b000010);
    chk("idle_cnt", cnt, 0);

    // single step, button held long
    lat = 3; req_hi = 0;
    b[2] = 1; cyc(50);
    chk("step_req_len", req_hi, 3);
    chk("step_cnt1", cnt, 1);
    chk("step_led", led, 6'b000010);
    b[2] = 0; cyc(1);

    // paced run, then stop
    lat = 1;
    b[0] = 1; cyc(1); b[0] = 0;
    req_hi = 0; cyc(12);
    chk("run_req_hi", req_hi, 4);
    chk("run_cnt", cnt, (1 + 4) % 4);
    b[3] = 1; cyc(1);
    chk("stop_drain_cnt", cnt, 2);
    chk("stop_led", led, 6'b000010);
    b[3] = 0; cyc(2);

    // halt during run
    lat = 2; h = 1;
    b[0] = 1; cyc(1); b[0] = 0; cyc(4); h = 0;
    chk("halt_cnt", cnt, 3);
    chk("halt_led", led, 6'b000010);

    // back to idle, then RUN+STOP together
    b[4] = 1; cyc(1); b[4] = 0; cyc(5);
    chk("resync_cnt", cnt, 0);
    b = 5'b01001; cyc(1);
    chk("runstop_req", req, 0);
    chk("runstop_led", led, 6'b000010);
    b = '0; cyc(1);

    // sync reset with request outstanding and same-cycle ack
    lat = 0;
    b[0] = 1; cyc(1); b[0] = 0; cyc(2);
    force_ack = 1; b[4] = 1; cyc(1);
    force_ack = 0; b[4] = 0;
    chk("rs_req", req, 0);
    chk("rs_cnt", cnt, 0);
    rst_hi = int'(crst);
    cyc(5);
    chk("rs_rst_len", rst_hi, RSTC);

    // ack timeout
    req_hi = 0;
    b[0] = 1; cyc(1); b[0] = 0; cyc(10);
    chk("to_req_hi", req_hi, TO);
    chk("fault_led", led, 6'b100000);
    b[0] = 1; cyc(1); b[0] = 0; cyc(1);
    chk("fault_sticky", led, 6'b100000);
    b[4] = 1; cyc(1); b[4] = 0; cyc(5);
    chk("fault_recover", led, 6'b000010);

    // counter wrap
    lat = 1;
    for (int k = 0; k < 4; k++) begin
      b[2] = 1; cyc(1); b[2] = 0; cyc(2);
      if (k == 2) chk("wrap_pre", cnt, 3);
    end
    chk("wrap", cnt, 0);

    // randomized traffic
    spur_en = 1;
    for (int k = 0; k < 3000; k++) begin
      if (k % 100 == 0) lat = $urandom_range(0, 4);
      for (int j = 0; j < 4; j++)
        if ($urandom_range(0, 9) == 0) b[j] = ~b[j];
      if ($urandom_range(0, 39) == 0) b[4] = ~b[4];
      h = ($urandom_range(0, 15) == 0);
      reset = ($urandom_range(0, 499) == 0);
      cyc(1);
    end
    reset = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mic1_run_ctrl.md
Name: mic1_run_ctrl

Overview:
Run/stop/single-step sequencer for the MIC-1 microarchitecture datapath, driven by the five debounced front-panel buttons.
- Converts button levels to press events.
- Paces microinstruction execution with a request/acknowledge handshake.
- Issues a timed synchronous reset to the datapath.
- Reports status on six LEDs.
- Sits between the button debouncers and the MIC-1 core.

Parameters:
RST_CYCLES, 4, number of cycles cpu_rst is held after any reset event (≥1)
RATE_DIV, 0, idle cycles inserted between consecutive microinstructions in RUN (0 = back-to-back)
ACK_TIMEOUT, 1023, max cycles cpu_req may wait for cpu_ack before FAULT
CNT_W, 16, width of the executed-microinstruction counter

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
btn  in  5  debounced button levels: [0]=RUN, [1]=unused, [2]=STEP_FW, [3]=STOP, [4]=RESET_SYNC
cpu_halt  in  1  level from datapath: halt microinstruction executed
cpu_ack  in  1  one-cycle pulse: requested microinstruction completed
cpu_req  out  1  request datapath to execute one microinstruction
cpu_rst  out  1  synchronous reset to datapath
step_cnt  out  CNT_W  microinstructions completed since last reset
led  out  6  status: [0]=RUN, [1]=STOP or IDLE, [2]=cpu_req outstanding, [3]=STEP, [4]=RST_HOLD, [5]=FAULT

Behaviour:
- One clock domain: clk. Reset is synchronous and active-high. All outputs are registered.
- Reset values:
  - state = RST_HOLD, hold counter = RST_CYCLES-1
  - cpu_req = 0, cpu_rst = 1, step_cnt = 0, led = 6'b010000
- Press event: rising edge of btn[i], detected against a registered copy (reset to 0). A button held high yields exactly one event. btn[1] is ignored.
- Simultaneous events, priority: RESET_SYNC > STOP > RUN > STEP_FW. Only the winner acts.
- States: RST_HOLD, IDLE, RUN, STOP, STEP, FAULT.
- RST_HOLD:
  - cpu_rst = 1 and cpu_req = 0.
  - Counter decrements each cycle; at 0, go to IDLE next cycle, so cpu_rst is high for exactly RST_CYCLES cycles.
  - All button events are ignored except RESET_SYNC, which reloads the counter.
- RESET_SYNC event in any state:
  - next state = RST_HOLD, counter reloaded, step_cnt cleared.
  - cpu_req drops next cycle even if an ack is pending; the transaction is abandoned.
- IDLE / STOP:
  - RUN event -> RUN.
  - STEP_FW event -> STEP.
  - STOP event in IDLE -> STOP.
- RUN:
  - Raise cpu_req. Hold it until a cycle with cpu_ack=1.
  - After each ack, cpu_req is low for RATE_DIV cycles, then re-raised. With RATE_DIV=0, cpu_req stays high and every ack cycle counts.
  - STOP event, or cpu_halt sampled high: set stop_pending. If no request is outstanding, go to STOP immediately. Otherwise go to STOP in the cycle after the next ack, with cpu_req low from that cycle.
  - RUN or STEP_FW events are ignored.
- STEP:
  - Raise cpu_req for exactly one transaction. On ack, drop cpu_req next cycle and go to STOP.
  - RUN and STEP_FW events are ignored. A STOP event sets stop_pending, which has the same effect as completing the step.
- Handshake rules:
  - cpu_req never falls before ack, except on a RESET_SYNC event or reset.
  - cpu_ack while cpu_req=0 is ignored and is not counted.
  - Ack in the same cycle as a RESET_SYNC event is not counted.
- step_cnt increments by 1 on every accepted ack and wraps modulo 2^CNT_W.
- Timeout:
  - Wait counter clears when cpu_req rises and increments while cpu_req=1 and cpu_ack=0.
  - Reaching ACK_TIMEOUT -> FAULT, with cpu_req = 0 next cycle.
  - FAULT exits only via RESET_SYNC or reset. led = 6'b100000 plus led[1]=0.
- led is registered from the next state, so LEDs change in the same cycle as the state.

Decomposition:
- Package mic1_ctrl_pkg holds:
  - typedef enum logic [2:0] run_state_t {RST_HOLD, IDLE, RUN, STOP, STEP, FAULT}
  - button index localparams BTN_RUN=0, BTN_STEP=2, BTN_STOP=3, BTN_RST=4
- Sub-module btn_edge_detect: parameterised width, registered prior level, outputs a one-cycle press vector. It is instantiated once for all 5 bits.

Test Plan:
- Reset, then idle: cpu_rst high exactly 4 cycles with RST_CYCLES=4, then IDLE with led=6'b000010, cpu_req=0, step_cnt=0.
- STEP_FW press with ack returned 3 cycles later: cpu_req high 3 cycles then low, step_cnt=1, final state STOP. Holding btn[2] for 50 cycles yields exactly one step.
- RUN with RATE_DIV=2 and ack 1 cycle after each req: req pattern 1,0,0 repeating, step_cnt +1 per period. STOP press mid-request drains that ack, then STOP with step_cnt incremented once more.
- RUN with cpu_halt asserted: completes the current ack, then STOP. RUN and STOP pressed in the same cycle from IDLE -> STOP.
- RESET_SYNC pressed while cpu_req outstanding: cpu_req=0 next cycle, same-cycle ack not counted, step_cnt=0, cpu_rst held 4 cycles.
- ACK_TIMEOUT=8 with no ack: FAULT after 8 waiting cycles, led[5]=1, cpu_req=0. RUN press ignored; RESET_SYNC recovers to IDLE. step_cnt wrap checked with CNT_W=2: 4 acks -> 0.
